count_seq_ctrl: RTL and testbench

// Run/pause/clear sequencer for the 8-bit display counter. Debounces two pushbuttons,

---
 rtl/count_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_count_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - run/pause/clear sequencer for the 8-bit display counter
// Optional build macro: AUTO_RELOAD_EN (terminal count wraps to 0 instead of entering DONE).

module count_seq_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic [CW-1:0] cnt;

    // stable only flips after DEB_CYCLES consecutive disagreeing samples; press fires on the falling flip
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync_2;
                    cnt    <= '0;
                    press  <= ~sync_2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module count_seq_ctrl #(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         TICK_HZ    = 1,
    parameter int         DEB_CYCLES = 1_000_000,
    parameter logic [7:0] MAX_COUNT  = 8'd99
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       KEY_go,
    input  logic       KEY_clr,
    input  logic [7:0] Q,
    output logic       En,
    output logic       Clr,
    output logic [1:0] State,
    output logic       Tick
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic          go_ev;
    logic          clr_ev;
    logic [PW-1:0] presc;
    logic [1:0]    state_next;
    logic          en_next;
    logic          clr_next;
    logic          at_max;

    count_seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_go (
        .clk   (CLOCK_50),
        .reset (Reset),
        .key   (KEY_go),
        .press (go_ev)
    );

    count_seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (CLOCK_50),
        .reset (Reset),
        .key   (KEY_clr),
        .press (clr_ev)
    );

    assign Tick   = (State == ST_RUN) && (presc == TICK_LAST);
    // an out-of-range preload behaves like reaching the terminal value
    assign at_max = (Q >= MAX_COUNT);

    always_comb begin
        state_next = State;
        en_next    = 1'b0;
        clr_next   = 1'b0;
        if (clr_ev) begin
            state_next = ST_IDLE;
            clr_next   = 1'b1;
        end else begin
            case (State)
                ST_IDLE: if (go_ev) state_next = ST_RUN;
                ST_RUN: begin
                    if (go_ev) begin
                        state_next = ST_PAUSE;
                    end else if (Tick) begin
                        if (at_max) begin
`ifdef AUTO_RELOAD_EN
                            clr_next = 1'b1;
`else
                            state_next = ST_DONE;
`endif
                        end else begin
                            en_next = 1'b1;
                        end
                    end
                end
                ST_PAUSE: if (go_ev) state_next = ST_RUN;
                ST_DONE: begin
                    if (go_ev) begin
                        state_next = ST_RUN;
                        clr_next   = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // prescaler only advances while staying in RUN, so a pause keeps the partial period
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            State <= ST_IDLE;
            En    <= 1'b0;
            Clr   <= 1'b0;
            presc <= '0;
        end else begin
            State <= state_next;
            En    <= en_next;
            Clr   <= clr_next;
            if (state_next == ST_IDLE || state_next == ST_DONE) begin
                presc <= '0;
            end else if (State == ST_RUN && state_next == ST_RUN) begin
                presc <= Tick ? '0 : presc + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - directed self-checking bench for count_seq_ctrl

module tb_count_seq_ctrl;
    logic       clk;
    logic       Reset;
    logic       KEY_go;
    logic       KEY_clr;
    logic [7:0] q;
    logic       En;
    logic       Clr;
    logic [1:0] State;
    logic       Tick;

    int n_tests = 0;
    int n_fail  = 0;
    int en_total = 0;
    int e0;

    count_seq_ctrl #(
        .CLK_HZ     (8),
        .TICK_HZ    (1),
        .DEB_CYCLES (4),
        .MAX_COUNT  (8'd5)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (Reset),
        .KEY_go   (KEY_go),
        .KEY_clr  (KEY_clr),
        .Q        (q),
        .En       (En),
        .Clr      (Clr),
        .State    (State),
        .Tick     (Tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counter datapath driven by the sequencer
    always @(posedge clk) begin
        if (Reset)    q <= 8'd0;
        else if (Clr) q <= 8'd0;
        else if (En)  q <= q + 8'd1;
    end

    always @(negedge clk) if (En) en_total <= en_total + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        Reset   = 1'b1;
        KEY_go  = 1'b1;
        KEY_clr = 1'b1;
        wait_n(2);
        Reset = 1'b0;
    endtask

    task automatic press_go;
        KEY_go = 1'b0;
        wait_n(7);
        KEY_go = 1'b1;
    endtask

    task automatic press_both;
        KEY_go  = 1'b0;
        KEY_clr = 1'b0;
        wait_n(7);
        KEY_go  = 1'b1;
        KEY_clr = 1'b1;
    endtask

    initial begin
        // reset, start, steady ticking, terminal count
        do_reset;
        check("rst_state", State, 0);
        check("rst_en", En, 0);
        check("rst_clr", Clr, 0);
        check("rst_tick", Tick, 0);
        KEY_go = 1'b0;
        wait_n(6);
        check("t1_idle_c6", State, 0);
        wait_n(1);
        check("t1_run_c7", State, 1);
        wait_n(3);
        KEY_go = 1'b1;
        wait_n(4);
        check("t1_tick_c14", Tick, 1);
        check("t1_no_en_c14", En, 0);
        wait_n(1);
        check("t1_en_c15", En, 1);
        wait_n(1);
        check("t1_q_c16", q, 1);
        wait_n(7);
        check("t1_en_c23", En, 1);
        wait_n(31);
        check("t2_tick_c54", Tick, 1);
        check("t2_q_c54", q, 5);
        wait_n(1);
`ifdef AUTO_RELOAD_EN
        check("t6_state_c55", State, 1);
        check("t6_clr_c55", Clr, 1);
        check("t6_no_en_c55", En, 0);
        wait_n(1);
        check("t6_q_wrap", q, 0);
        wait_n(8);
        check("t6_q_next", q, 1);
        check("t6_state_run", State, 1);
`else
        check("t2_done_c55", State, 3);
        check("t2_no_en_c55", En, 0);
        e0 = en_total;
        wait_n(20);
        check("t2_no_more_en", en_total, e0);
        check("t2_q_hold", q, 5);
        check("t2_state_hold", State, 3);
        check("t2_no_tick", Tick, 0);
        press_go;
        check("t2_restart_state", State, 1);
        check("t2_restart_clr", Clr, 1);
        check("t2_restart_no_en", En, 0);
        wait_n(1);
        check("t2_restart_q", q, 0);
`endif

        // pause mid-period and resume with the remaining prescaler cycles
        do_reset;
        press_go;
        check("t3_run", State, 1);
        wait_n(12);
        press_go;
        check("t3_pause", State, 2);
        check("t3_pause_no_en", En, 0);
        check("t3_pause_q", q, 2);
        wait_n(11);
        check("t3_pause_hold", State, 2);
        check("t3_pause_q_hold", q, 2);
        press_go;
        check("t3_resume", State, 1);
        wait_n(4);
        check("t3_no_tick_early", Tick, 0);
        wait_n(1);
        check("t3_tick_resume", Tick, 1);
        wait_n(1);
        check("t3_en_resume", En, 1);
        wait_n(1);
        check("t3_q_resume", q, 3);

        // coincident go and clr while running
        do_reset;
        press_go;
        wait_n(12);
        press_both;
        check("t5_state", State, 0);
        check("t5_clr", Clr, 1);
        check("t5_no_en", En, 0);
        wait_n(1);
        check("t5_clr_one", Clr, 0);
        check("t5_q", q, 0);

        // bouncing key produces no event
        do_reset;
        KEY_go = 1'b0;
        wait_n(2);
        KEY_go = 1'b1;
        wait_n(1);
        KEY_go = 1'b0;
        wait_n(2);
        KEY_go = 1'b1;
        wait_n(10);
        check("t4_bounce_state", State, 0);
        check("t4_bounce_clr", Clr, 0);

        // reset mid-run
        do_reset;
        press_go;
        wait_n(9);
        check("rr_q", q, 1);
        Reset = 1'b1;
        wait_n(1);
        check("rr_state", State, 0);
        check("rr_en", En, 0);
        check("rr_clr", Clr, 0);
        check("rr_tick", Tick, 0);
        Reset = 1'b0;
        wait_n(10);
        check("rr_stays_idle", State, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
